matrix_mult_param: RTL

MATRIX_MULT_PARAM -- requirements
Module: matrix_mult_param

---
 rtl/matrix_mult_param.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/matrix_mult_param.sv
// matrix_mult_param: sequential signed fixed-point matrix multiply C = A x B.
// A (MxN) and B (NxP) live in internal register files loaded while idle.
// One product is accumulated per cycle; each C element is then presented
// on a valid/ready port, scaled by FRAC_BITS and saturated to DATA_WIDTH.
module matrix_mult_param #(
  parameter int M          = 3,
  parameter int N          = 3,
  parameter int P          = 3,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  localparam int ACC_WIDTH = 2*DATA_WIDTH + (($clog2(N) > 1) ? $clog2(N) : 1),
  localparam int AAW       = $clog2(M*N),
  localparam int BAW       = $clog2(N*P),
  localparam int RW        = ($clog2(M) > 1) ? $clog2(M) : 1,
  localparam int CW        = ($clog2(P) > 1) ? $clog2(P) : 1
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic [AAW-1:0]              a_addr,
  input  logic                        a_wen,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  input  logic [BAW-1:0]              b_addr,
  input  logic                        b_wen,
  output logic signed [DATA_WIDTH-1:0] c_out,
  output logic signed [ACC_WIDTH-1:0]  c_raw,
  output logic                        c_sat,
  output logic                        c_valid,
  input  logic                        c_ready,
  output logic [RW-1:0]               row,
  output logic [CW-1:0]               col,
  output logic                        busy,
  output logic                        done
);
  localparam int KW = ($clog2(N) > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;
  state_t state, state_nx;

  logic signed [DATA_WIDTH-1:0] a_mem [M*N];
  logic signed [DATA_WIDTH-1:0] b_mem [N*P];

  logic [KW-1:0]                k;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [AAW-1:0]               a_idx;
  logic [BAW-1:0]               b_idx;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext, sum, shifted, max_v, min_v;
  logic                         sat_hi, sat_lo;
  logic [DATA_WIDTH-1:0]        clamped;
  logic                         start_ok, last_k, hs, last_elem;

  // A start landing on the done pulse is dropped so a finished run cannot
  // chain straight into another one.
  assign start_ok  = start && (state == IDLE) && !done;
  assign last_k    = (k == KW'(N-1));
  assign hs        = (state == OUT) && c_valid && c_ready;
  assign last_elem = (row == RW'(M-1)) && (col == CW'(P-1));

  assign a_idx    = AAW'(32'(row) * N + 32'(k));
  assign b_idx    = BAW'(32'(k) * P + 32'(col));
  assign prod     = a_mem[a_idx] * b_mem[b_idx];
  assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  assign sum      = acc + prod_ext;
  // Arithmetic shift rounds toward minus infinity, then clamp to the
  // signed DATA_WIDTH range.
  assign shifted  = sum >>> FRAC_BITS;
  assign max_v    = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  assign min_v    = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  assign sat_hi   = shifted > max_v;
  assign sat_lo   = shifted < min_v;
  assign clamped  = sat_hi ? max_v[DATA_WIDTH-1:0] :
                    sat_lo ? min_v[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

  // Operand storage: written only while idle and in range; never reset.
  always_ff @(posedge clk) begin
    if (a_wen && !busy && ({1'b0, a_addr} < (AAW+1)'(M*N))) a_mem[a_addr] <= a_in;
    if (b_wen && !busy && ({1'b0, b_addr} < (BAW+1)'(N*P))) b_mem[b_addr] <= b_in;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = MAC;
      MAC:     if (last_k) state_nx = OUT;
      OUT:     if (hs) state_nx = last_elem ? DONE : MAC;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: accumulate, latch the scaled result, walk C in row-major order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc     <= '0;
      k       <= '0;
      row     <= '0;
      col     <= '0;
      c_out   <= '0;
      c_raw   <= '0;
      c_sat   <= 1'b0;
      c_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state == DONE);
      case (state)
        IDLE: if (start_ok) begin
          acc <= '0;
          k   <= '0;
          row <= '0;
          col <= '0;
        end
        MAC: begin
          acc <= sum;
          k   <= k + 1'b1;
          if (last_k) begin
            k       <= '0;
            c_raw   <= sum;
            c_out   <= clamped;
            c_sat   <= sat_hi | sat_lo;
            c_valid <= 1'b1;
          end
        end
        OUT: if (hs) begin
          c_valid <= 1'b0;
          acc     <= '0;
          if (col == CW'(P-1)) begin
            col <= '0;
            row <= last_elem ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
